stack_seq: RTL and testbench

- Sequences push/pop/peek operations for the processor stack against a single-port data memory.
- Owns the stack pointer register, performs full/empty bounds checks and runs the memory request/ack handshake.
- Returns popped data to the datapath.
- Sits between instruction decode (which issues decoded stack ops) and the shared data-memory port.

---
 rtl/stack_seq_pkg.sv | 23 ++
 rtl/stack_seq_if.sv | 33 +++
 rtl/stack_ptr_reg.sv | 45 ++++
 rtl/stack_seq.sv | 155 +++++++++++++++
 tb/tb_stack_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types and default geometry for the stack sequencer.
// Build option: define STACK_PEEK_EN to add the non-destructive PEEK state.
package stack_seq_pkg;

  localparam int unsigned PTR_W_DEF       = 9;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam logic [8:0]  STACK_BASE_DEF  = 9'h100;
  localparam int unsigned STACK_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    SOP_NOP  = 2'd0,
    SOP_PUSH = 2'd1,
    SOP_POP  = 2'd2,
    SOP_PEEK = 2'd3
  } stack_op_t;

`ifdef STACK_PEEK_EN
  typedef enum logic [1:0] {StIdle, StWr, StRd, StPk} seq_state_t;
`else
  typedef enum logic [1:0] {StIdle, StWr, StRd} seq_state_t;
`endif

endpackage

// File: rtl/stack_seq_if.sv
// Decoded-op channel plus single-port data-memory channel of the stack sequencer.
// master = sequencer side, slave = issuer/memory side.
interface stack_seq_if #(
  parameter int unsigned PTR_W  = stack_seq_pkg::PTR_W_DEF,
  parameter int unsigned DATA_W = stack_seq_pkg::DATA_W_DEF
);
  import stack_seq_pkg::*;

  logic              op_valid;
  stack_op_t         op_kind;
  logic [DATA_W-1:0] op_wdata;
  logic              op_ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              mem_req;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  op_valid, op_kind, op_wdata, mem_ack, mem_rdata,
    output op_ready, done, rdata, rdata_valid, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output op_valid, op_kind, op_wdata, mem_ack, mem_rdata,
    input  op_ready, done, rdata, rdata_valid, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/stack_ptr_reg.sv
// Stack pointer register with increment/decrement/hold and empty/full flags.
module stack_ptr_reg
  import stack_seq_pkg::*;
#(
  parameter int unsigned      PTR_W       = PTR_W_DEF,
  parameter logic [PTR_W-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter int unsigned      STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             empty_o,
  output logic             full_o
);

  // Full marker is BASE + DEPTH taken to PTR_W bits; at the defaults 0x200 aliases to 0x000,
  // which is still distinct from the empty value, so the bounds checks stay exact.
  localparam logic [PTR_W-1:0] FullPtr = PTR_W'(32'(STACK_BASE) + STACK_DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign ptr_o   = ptr_q;
  assign empty_o = (ptr_q == STACK_BASE);
  assign full_o  = (ptr_q == FullPtr);

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i && !full_o) begin
      ptr_d = ptr_q + PTR_W'(1);
    end else if (dec_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= STACK_BASE;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stack_seq.sv
// Stack op sequencer: bounds checks, pointer ownership and memory req/ack handshake.
// Build option: STACK_PEEK_EN enables SOP_PEEK via state StPk; otherwise PEEK retires as NOP.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int unsigned      PTR_W       = PTR_W_DEF,
  parameter int unsigned      DATA_W      = DATA_W_DEF,
  parameter logic [PTR_W-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter int unsigned      STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  stack_seq_if.master      bus,
  input  logic             err_clr_i,
  output logic [PTR_W-1:0] stack_ptr_o,
  output logic             err_overflow_o,
  output logic             err_underflow_o
);

  seq_state_t        state_q;
  logic              mem_req_q, mem_we_q, done_q, rdata_valid_q;
  logic              err_ovf_q, err_unf_q;
  logic [PTR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;
  logic [PTR_W-1:0]  ptr;
  logic              ptr_inc, ptr_dec, empty, full;

  assign ptr_inc = (state_q == StWr) && bus.mem_ack;
  assign ptr_dec = (state_q == StRd) && bus.mem_ack;

  stack_ptr_reg #(
    .PTR_W       (PTR_W),
    .STACK_BASE  (STACK_BASE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ptr_inc),
    .dec_i   (ptr_dec),
    .ptr_o   (ptr),
    .empty_o (empty),
    .full_o  (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      // Later set assignments below override this, so a coincident new error wins.
      if (err_clr_i) begin
        err_ovf_q <= 1'b0;
        err_unf_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            unique case (bus.op_kind)
              SOP_PUSH: begin
                if (full) begin
                  err_ovf_q <= 1'b1;
                  done_q    <= 1'b1;
                end else begin
                  mem_addr_q  <= ptr;
                  mem_wdata_q <= bus.op_wdata;
                  mem_we_q    <= 1'b1;
                  mem_req_q   <= 1'b1;
                  state_q     <= StWr;
                end
              end
              SOP_POP: begin
                if (empty) begin
                  err_unf_q <= 1'b1;
                  done_q    <= 1'b1;
                end else begin
                  mem_addr_q <= ptr - PTR_W'(1);
                  mem_we_q   <= 1'b0;
                  mem_req_q  <= 1'b1;
                  state_q    <= StRd;
                end
              end
`ifdef STACK_PEEK_EN
              SOP_PEEK: begin
                if (empty) begin
                  err_unf_q <= 1'b1;
                  done_q    <= 1'b1;
                end else begin
                  mem_addr_q <= ptr - PTR_W'(1);
                  mem_we_q   <= 1'b0;
                  mem_req_q  <= 1'b1;
                  state_q    <= StPk;
                end
              end
`endif
              default: done_q <= 1'b1;
            endcase
          end
        end
        StWr: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StRd: begin
          if (bus.mem_ack) begin
            rdata_q       <= bus.mem_rdata;
            mem_req_q     <= 1'b0;
            done_q        <= 1'b1;
            rdata_valid_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
`ifdef STACK_PEEK_EN
        StPk: begin
          if (bus.mem_ack) begin
            rdata_q       <= bus.mem_rdata;
            mem_req_q     <= 1'b0;
            done_q        <= 1'b1;
            rdata_valid_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.op_ready    = (state_q == StIdle);
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

  assign stack_ptr_o     = ptr;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a behavioural memory responder of programmable wait.
module tb_stack_seq;
  import stack_seq_pkg::*;

  // Full marker: BASE + DEPTH taken to the 9-bit pointer width.
  localparam logic [8:0] FullPtr = 9'(32'h100 + 32'd256);

  logic       clk = 1'b1;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [8:0] stack_ptr;
  logic       err_ovf, err_unf;

  stack_seq_if #(.PTR_W(9), .DATA_W(8)) bus ();

  stack_seq #(
    .PTR_W       (9),
    .DATA_W      (8),
    .STACK_BASE  (9'h100),
    .STACK_DEPTH (256)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .err_clr_i       (err_clr),
    .stack_ptr_o     (stack_ptr),
    .err_overflow_o  (err_ovf),
    .err_underflow_o (err_unf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem [512];
  int         ack_wait = 0;
  int         wait_cnt = 0;
  int         req_cycles = 0;
  int         done_seen = 0;
  logic [8:0] last_addr = '0;
  logic       last_we = 1'b0;
  logic [7:0] last_wdata = '0;

  // Memory responder: acks after ack_wait wait cycles of mem_req.
  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      req_cycles++;
      if (wait_cnt >= ack_wait) begin
        bus.mem_ack = 1'b1;
        wait_cnt    = 0;
        last_addr   = bus.mem_addr;
        last_we     = bus.mem_we;
        last_wdata  = bus.mem_wdata;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata     = mem[bus.mem_addr];
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one op for a cycle, then waits (bounded) for done; lat counts cycles after accept.
  task automatic issue(input stack_op_t kind, input logic [7:0] wd, input logic clr,
                       output int lat);
    step();
    bus.op_valid = 1'b1;
    bus.op_kind  = kind;
    bus.op_wdata = wd;
    err_clr      = clr;
    step();
    bus.op_valid = 1'b0;
    err_clr      = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int rc0;
    int d0;
    bus.op_valid = 1'b0;
    bus.op_kind  = SOP_NOP;
    bus.op_wdata = '0;
    repeat (3) step();

    check("rst_ptr",       32'(stack_ptr),       32'h100);
    check("rst_op_ready",  32'(bus.op_ready),    32'd1);
    check("rst_done",      32'(bus.done),        32'd0);
    check("rst_rvalid",    32'(bus.rdata_valid), 32'd0);
    check("rst_mem_req",   32'(bus.mem_req),     32'd0);
    check("rst_mem_we",    32'(bus.mem_we),      32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),    32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata),   32'd0);
    check("rst_rdata",     32'(bus.rdata),       32'd0);
    check("rst_ovf",       32'(err_ovf),         32'd0);
    check("rst_unf",       32'(err_unf),         32'd0);
    rst_n = 1'b1;

    // Zero-wait push
    ack_wait = 0;
    rc0 = req_cycles;
    issue(SOP_PUSH, 8'hA5, 1'b0, lat);
    check("push_lat",   32'(lat),              32'd2);
    check("push_req",   32'(req_cycles - rc0), 32'd1);
    check("push_addr",  32'(last_addr),        32'h100);
    check("push_we",    32'(last_we),          32'd1);
    check("push_wdata", 32'(last_wdata),       32'hA5);
    check("push_ptr",   32'(stack_ptr),        32'h101);
    check("push_rv",    32'(bus.rdata_valid),  32'd0);

    // Two pushes, then pops with 3-cycle request each
    issue(SOP_PUSH, 8'h11, 1'b0, lat);
    issue(SOP_PUSH, 8'h22, 1'b0, lat);
    check("push3_ptr", 32'(stack_ptr), 32'h103);
    ack_wait = 2;
    rc0 = req_cycles;
    issue(SOP_POP, 8'h00, 1'b0, lat);
    check("pop1_lat",   32'(lat),              32'd4);
    check("pop1_req",   32'(req_cycles - rc0), 32'd3);
    check("pop1_addr",  32'(last_addr),        32'h102);
    check("pop1_we",    32'(last_we),          32'd0);
    check("pop1_rdata", 32'(bus.rdata),        32'h22);
    check("pop1_rv",    32'(bus.rdata_valid),  32'd1);
    rc0 = req_cycles;
    issue(SOP_POP, 8'h00, 1'b0, lat);
    check("pop2_req",   32'(req_cycles - rc0), 32'd3);
    check("pop2_rdata", 32'(bus.rdata),        32'h11);
    check("pop2_ptr",   32'(stack_ptr),        32'h101);
    ack_wait = 0;
    issue(SOP_POP, 8'h00, 1'b0, lat);
    check("pop3_rdata", 32'(bus.rdata), 32'hA5);
    check("pop3_ptr",   32'(stack_ptr), 32'h100);
    step();
    check("rdata_hold", 32'(bus.rdata),       32'hA5);
    check("rv_pulse",   32'(bus.rdata_valid), 32'd0);

    // Pop on empty, sticky underflow and clear priority
    rc0 = req_cycles;
    issue(SOP_POP, 8'h00, 1'b0, lat);
    check("upop_lat", 32'(lat),              32'd1);
    check("upop_req", 32'(req_cycles - rc0), 32'd0);
    check("upop_unf", 32'(err_unf),          32'd1);
    check("upop_ovf", 32'(err_ovf),          32'd0);
    check("upop_ptr", 32'(stack_ptr),        32'h100);
    step();
    check("unf_sticky", 32'(err_unf), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("unf_clr", 32'(err_unf), 32'd0);
    issue(SOP_POP, 8'h00, 1'b1, lat);
    check("unf_set_wins", 32'(err_unf), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Fill to full, then overflow
    for (int i = 0; i < 256; i++) issue(SOP_PUSH, 8'(i), 1'b0, lat);
    check("fill_ptr",  32'(stack_ptr), 32'(FullPtr));
    check("fill_addr", 32'(last_addr), 32'h1FF);
    rc0 = req_cycles;
    issue(SOP_PUSH, 8'h77, 1'b0, lat);
    check("ovf_lat", 32'(lat),              32'd1);
    check("ovf_req", 32'(req_cycles - rc0), 32'd0);
    check("ovf_flag", 32'(err_ovf),         32'd1);
    check("ovf_ptr", 32'(stack_ptr),        32'(FullPtr));
    issue(SOP_POP, 8'h00, 1'b0, lat);
    check("top_rdata", 32'(bus.rdata), 32'hFF);
    check("top_ptr",   32'(stack_ptr), 32'h1FF);

    // Reset in the middle of a write wait
    do_reset();
    check("rst2_ptr",   32'(stack_ptr), 32'h100);
    check("rst2_rdata", 32'(bus.rdata), 32'd0);
    check("rst2_ovf",   32'(err_ovf),   32'd0);
    ack_wait = 20;
    d0 = done_seen;
    step();
    bus.op_valid = 1'b1;
    bus.op_kind  = SOP_PUSH;
    bus.op_wdata = 8'h5A;
    step();
    bus.op_valid = 1'b0;
    check("wr_req",   32'(bus.mem_req),  32'd1);
    check("wr_ready", 32'(bus.op_ready), 32'd0);
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_ptr", 32'(stack_ptr),   32'h100);
    rst_n = 1'b1;
    repeat (4) step();
    check("mid_rst_done",  32'(done_seen - d0), 32'd0);
    check("mid_rst_ready", 32'(bus.op_ready),   32'd1);
    check("mid_rst_ptr2",  32'(stack_ptr),      32'h100);
    ack_wait = 0;

    // Peek
    issue(SOP_PUSH, 8'h3C, 1'b0, lat);
`ifdef STACK_PEEK_EN
    for (int k = 0; k < 2; k++) begin
      rc0 = req_cycles;
      issue(SOP_PEEK, 8'h00, 1'b0, lat);
      check("peek_lat",   32'(lat),              32'd2);
      check("peek_req",   32'(req_cycles - rc0), 32'd1);
      check("peek_rdata", 32'(bus.rdata),        32'h3C);
      check("peek_rv",    32'(bus.rdata_valid),  32'd1);
      check("peek_ptr",   32'(stack_ptr),        32'h101);
    end
`else
    rc0 = req_cycles;
    issue(SOP_PEEK, 8'h00, 1'b0, lat);
    check("peek_nop_lat", 32'(lat),              32'd1);
    check("peek_nop_req", 32'(req_cycles - rc0), 32'd0);
    check("peek_nop_unf", 32'(err_unf),          32'd0);
    check("peek_nop_ptr", 32'(stack_ptr),        32'h101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
